// File: rtl/md_pkg.sv
// md_pkg: definitions shared by the multiply/divide sequencer and its
// combinational result generator.
//   - md_op_e     : command encodings presented on the 3-bit op port
//   - md_state_e  : sequencer states
//   - md_result_t : a {hi, lo} result pair
//   - MD_CNT_W    : width of the latency down-counter
//   - is_muldiv() : true for the commands that occupy the unit for several cycles
package md_pkg;

    localparam int MD_CNT_W = 4;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        logic r;
        case (md_op_e'(op))
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: purely combinational result generator for the mult/div unit.
// Ports:
//   op       in   3  command code (md_op_e)
//   a, b     in  32  rs / rt operands
//   result   out 64  {hi, lo}: product, or {remainder, quotient}; 0 for other ops
//   div_zero out  1  DIV/DIVU with b == 0 (result must not be committed)
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_result_t  result,
    output logic        div_zero
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;

    logic [31:0] b_safe;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Sign-extended operands; the low 64 bits of the product are exact.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the dividers never see 0; the
    // result is discarded anyway through div_zero.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;
    assign q_u    = a / b_safe;
    assign r_u    = a % b_safe;

    // Signed divide on magnitudes. The 32-bit magnitude of 0x80000000 is
    // 2^31 read as unsigned, so 0x80000000 / -1 wraps to 0x80000000 with
    // remainder 0 rather than trapping.
    assign mag_a = a[31]      ? (~a + 32'd1)      : a;
    assign mag_b = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    assign q_mag = mag_a / mag_b;
    assign r_mag = mag_a % mag_b;
    assign q_s   = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = a[31]                ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned, which would infer a latch.
        result   = '0;
        div_zero = 1'b0;
        case (md_op_e'(op))
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result   = {r_s, q_s};
                div_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                result   = {r_u, q_u};
                div_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage multiply/divide sequencer owning HI/LO.
// A mult/div command accepted in IDLE has its result computed at once by
// md_calc and parked in pending registers; a down-counter then holds busy
// for MUL_CYCLES / DIV_CYCLES cycles before the pending pair is committed.
// MTHI/MTLO write HI/LO directly from IDLE. Commands arriving while busy are
// dropped; the pipeline stalls on md_stall.
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous active-low reset
//   start    in   1  command valid this cycle
//   op       in   3  command code (md_op_e)
//   a, b     in  32  rs / rt operands
//   busy     out  1  operation in flight (registered)
//   hi, lo   out 32  committed HI / LO registers
//   md_stall out  1  busy, or a mult/div being presented this cycle
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [MD_CNT_W-1:0] MUL_CNT = MD_CNT_W'(MUL_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_CNT = MD_CNT_W'(DIV_CYCLES);

    md_state_e            state_q, state_d;
    logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;
    md_result_t           pend_q, pend_d;
    logic                 pend_wr_q, pend_wr_d;

    md_result_t           calc_res;
    logic                 calc_div_zero;
    md_op_e               op_e;

    assign op_e = md_op_e'(op);

    md_calc u_calc (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (calc_res),
        .div_zero (calc_div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_e)
                        MD_MULT, MD_MULTU: begin
                            pend_d    = calc_res;
                            pend_wr_d = 1'b1;
                            cnt_d     = MUL_CNT;
                            state_d   = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero still takes the full latency but
                            // leaves HI/LO untouched at completion.
                            pend_d    = calc_res;
                            pend_wr_d = ~calc_div_zero;
                            cnt_d     = DIV_CNT;
                            state_d   = ST_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here: no capture, no queue.
                if (cnt_q <= MD_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending registers are cleared with everything else so an aborted
    // operation can never leak a result after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_stall = busy | (start & is_muldiv(op));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl with default latencies (5 / 10).
// Table-driven vectors run back to back; hand-written sequences cover a
// command dropped while busy and an asynchronous reset mid-operation.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    int checks;
    int failures;

    md_unit_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_stall (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] eh, input logic [31:0] el, input int c);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.exp_hi = eh; v.exp_lo = el; v.cycles = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int n;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        op       = 3'd0;
        a        = '0;
        b        = '0;

        // Vectors run in order; expected HI/LO include state left by earlier rows.
        vecs.push_back(mk(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5));  // MULT -2*3
        vecs.push_back(mk(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5));  // MULTU max*max
        vecs.push_back(mk(3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10)); // DIV -7/2
        vecs.push_back(mk(3'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10)); // DIVU /0 unchanged
        vecs.push_back(mk(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10)); // DIV overflow
        vecs.push_back(mk(3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 0));  // MTHI
        vecs.push_back(mk(3'd6, 32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0));  // MTLO
        vecs.push_back(mk(3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10)); // DIVU 100/7
        vecs.push_back(mk(3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10)); // DIV 7/-2
        vecs.push_back(mk(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5));  // MULT max pos
        vecs.push_back(mk(3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 5));  // MULT -3*-5
        vecs.push_back(mk(3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5));  // MULTU carry
        vecs.push_back(mk(3'd0, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'h00000000, 0));  // NOP
        vecs.push_back(mk(3'd7, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'h00000000, 0));  // illegal op
        vecs.push_back(mk(3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000000, 10)); // DIV /0 unchanged

        // Reset state.
        reset = 1'b0;
        #12;
        check("rst_busy",  busy,     32'd0);
        check("rst_hi",    hi,       32'd0);
        check("rst_lo",    lo,       32'd0);
        check("rst_stall", md_stall, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        prev_hi = 32'd0;
        prev_lo = 32'd0;
        foreach (vecs[i]) begin
            @(negedge clk);
            start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            #1;
            check($sformatf("v%0d_busy_pre", i), busy, 32'd0);
            check($sformatf("v%0d_stall_comb", i), md_stall, (vecs[i].cycles != 0) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0; op = 3'd0;
            n = 0;
            while (busy && n < 40) begin
                if (n == 0) begin
                    check($sformatf("v%0d_hi_stale", i), hi, prev_hi);
                    check($sformatf("v%0d_stall_busy", i), md_stall, 32'd1);
                end
                n++;
                @(posedge clk);
                #1;
            end
            check($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            prev_hi = vecs[i].exp_hi;
            prev_lo = vecs[i].exp_lo;
        end

        // MULT presented during cycles 2..4 of a DIV is dropped.
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'h00000064; b = 32'h00000007;  // DIV 100/7
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n >= 2 && n <= 4) begin
                start = 1'b1; op = 3'd1; a = 32'h2; b = 32'h3;
                #1;
                check($sformatf("ovl_stall_%0d", n), md_stall, 32'd1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; op = 3'd0;
        check("ovl_cycles", n, 32'd10);
        check("ovl_hi", hi, 32'h00000002);
        check("ovl_lo", lo, 32'h0000000E);
        @(posedge clk);
        #1;
        check("ovl_idle_after", busy, 32'd0);

        // Asynchronous reset in cycle 3 of a MULT aborts it.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'h2; b = 32'h3;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_busy_before", busy, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 32'd0);
        check("abort_hi",   hi,   32'd0);
        check("abort_lo",   lo,   32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_busy_after", busy, 32'd0);
        check("abort_hi_after",   hi,   32'd0);
        check("abort_lo_after",   lo,   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multiply/divide sequencer for the pipelined MIPS CPU, sitting in the E stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and owns the HI/LO registers.
- Models fixed multi-cycle latency with a down-counter and `busy` flag, so hazard logic can stall MFHI/MFLO and further mult/div instructions.
- Single clock domain.

Parameters:
- MUL_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO update (range 1..15)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO update (range 1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  command valid this cycle (E-stage instruction is a mult/div/mt op)
- op  input  3  command code (package encodings)
- a  input  32  rs operand
- b  input  32  rt operand
- busy  output  1  operation in flight (registered)
- hi  output  32  HI register
- lo  output  32  LO register
- md_stall  output  1  combinational: busy | (start & op is MULT/MULTU/DIV/DIVU)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset=0: state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result regs=0.
  - Reset mid-operation aborts the operation; no HI/LO update occurs.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter>0).
  - No other states.
- IDLE with start=1, sampled at edge T0:
  - MULT: pending {hi,lo} = signed 64-bit a*b. Counter=MUL_CYCLES. Go to RUN.
  - MULTU: same as MULT but unsigned.
  - DIV: pending lo = signed a/b (truncate toward zero), pending hi = signed remainder (sign follows dividend). Counter=DIV_CYCLES. Go to RUN.
  - DIVU: same as DIV but unsigned quotient and remainder.
  - MTHI: hi <= a at T0. Stay IDLE, busy stays 0.
  - MTLO: lo <= a at T0. Stay IDLE, busy stays 0.
  - NOP code: no effect.
- Divide by zero (b=0) on DIV/DIVU:
  - Timing still runs for DIV_CYCLES.
  - HI/LO are left unchanged at completion.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter goes 1->0: hi/lo <= pending, busy <= 0, state <= IDLE.
  - busy is high for exactly N cycles (edges T0..T0+N-1 produce busy=1; result is visible after edge T0+N).
- start while busy=1: ignored entirely (operands not captured, HI/LO not written).
  - The pipeline is required to stall; the block does not queue.
- hi/lo outputs always show the committed registers.
  - The pending result is never visible before completion.
  - MFHI/MFLO issued while busy read stale values; hazard logic must use md_stall.
- Illegal op codes: treated as NOP.
- Arithmetic: full 64-bit products; no overflow traps.
  - Signed DIV of 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.

Decomposition:
- Shared package (md_pkg):
  - op encodings: MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - Counter width constant MD_CNT_W=4.
- One natural sub-module, md_calc: purely combinational 64-bit result generator (product/quotient/remainder, divide-by-zero flag).
- Counter/FSM and HI/LO registers stay in md_unit_ctrl.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy=1 for 5 cycles; after 5th edge hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 -> 10 busy cycles; hi/lo unchanged.
- MTHI a=0x12345678 at idle -> hi=0x12345678 next edge, busy never asserts.
  - MULT issued while busy (cycle 2 of a DIV) -> ignored; final hi/lo reflect the DIV only; md_stall=1 throughout.
- Reset pulled low at cycle 3 of a MULT -> busy=0, hi=lo=0 immediately (asynchronous); no update after release.
- start=1 with op=MULT in IDLE -> md_stall=1 in the same cycle (combinational) while busy is still 0.
